stream_rr_arbiter: RTL and testbench

Parametrised N-channel merge stage that replaces the fixed-priority module-data multiplexer in front of the GigEx transmit path. Each frontend module FIFO presents 128-bit single/timetag words on a valid/ready stream. The block merges them onto one registered output stream using masked round-robin arbitration. It also maintains per-channel singles, timetag and stall counters that the MicroBlaze can select, read and clear.

---
 rtl/backend_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 41 ++++
 rtl/stream_rr_arbiter.sv | 137 +++++++++++++
 tb/tb_stream_rr_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/backend_pkg.sv
// Shared constants for the GigEx transmit back-end: word flag positions and
// counter type encodings.
package backend_pkg;

  localparam int unsigned SGL_FLAG_OFFSET_DEF = 122;
  localparam int unsigned CMD_FLAG_OFFSET_DEF = 123;

  typedef enum logic [1:0] {
    CNT_SGL   = 2'd0,
    CNT_TT    = 2'd1,
    CNT_STALL = 2'd2,
    CNT_NONE  = 2'd3
  } cnt_type_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: lowest eligible channel at or above ptr,
// wrapping to the lowest eligible channel overall.
module rr_arbiter #(
  parameter int unsigned NCH = 4,
  parameter int unsigned CHW = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [NCH-1:0] enable,
  input  logic [CHW-1:0] ptr,
  output logic [NCH-1:0] grant,
  output logic [CHW-1:0] idx
);

  logic [NCH-1:0]   elig;
  logic [NCH-1:0]   upper;
  logic [2*NCH-1:0] dbl;
  logic             found;

  // Low half holds channels >= ptr, high half the full set for the wrap.
  always_comb begin
    elig  = req & enable;
    upper = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      upper[i] = (i >= 32'(ptr));
    end
    dbl   = {elig, elig & upper};
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 2*NCH; i++) begin
      if (!found && dbl[i]) begin
        found = 1'b1;
        idx   = CHW'(i % NCH);
      end
    end
    for (int unsigned i = 0; i < NCH; i++) begin
      grant[i] = found && (idx == CHW'(i));
    end
  end

endmodule

// File: rtl/stream_rr_arbiter.sv
// N-channel valid/ready merge with round-robin arbitration, one output
// register, and per-channel singles / timetag / stall counters.
module stream_rr_arbiter
  import backend_pkg::*;
#(
  parameter int unsigned NCH             = 4,
  parameter int unsigned LENGTH          = 128,
  parameter int unsigned SGL_FLAG_OFFSET = SGL_FLAG_OFFSET_DEF,
  parameter int unsigned CNT_WIDTH       = 48,
  parameter int unsigned CHW             = $clog2(NCH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH*LENGTH-1:0] in_data,
  input  logic [NCH-1:0]        in_valid,
  output logic [NCH-1:0]        in_ready,
  input  logic [NCH-1:0]        chan_mask,
  output logic [LENGTH-1:0]     out_data,
  output logic [CHW-1:0]        out_chan,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic [CHW-1:0]        cnt_sel_chan,
  input  logic [1:0]            cnt_sel_type,
  input  logic [2:0]            cnt_load,
  output logic [CNT_WIDTH-1:0]  cnt_value
);

  logic [CHW-1:0]                ptr;
  logic [CHW-1:0]                gnt_idx;
  logic [NCH-1:0]                gnt;
  logic                          slot_free;
  logic                          take;
  logic [LENGTH-1:0]             gnt_data;
  logic [NCH-1:0][CNT_WIDTH-1:0] cnt_sgl;
  logic [NCH-1:0][CNT_WIDTH-1:0] cnt_tt;
  logic [NCH-1:0][CNT_WIDTH-1:0] cnt_stall;
  logic [CNT_WIDTH-1:0]          rd_value;

  rr_arbiter #(
    .NCH (NCH),
    .CHW (CHW)
  ) u_arb (
    .req    (in_valid),
    .enable (chan_mask),
    .ptr    (ptr),
    .grant  (gnt),
    .idx    (gnt_idx)
  );

  // Accept at most one word, only when the output slot frees this cycle.
  always_comb begin
    slot_free = ~out_valid | out_ready;
    take      = slot_free & ~rst & (|gnt);
    in_ready  = take ? gnt : '0;
  end

  always_comb begin
    gnt_data = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (gnt_idx == CHW'(i)) gnt_data = in_data[i*LENGTH +: LENGTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= '0;
    end else if (take) begin
      out_valid <= 1'b1;
      out_data  <= gnt_data;
      out_chan  <= gnt_idx;
      ptr       <= (gnt_idx == CHW'(NCH-1)) ? '0 : gnt_idx + CHW'(1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_cnt
    logic                 sel;
    logic                 xfer;
    logic                 is_sgl;
    logic                 stall;
    logic [CNT_WIDTH-1:0] sgl_q;
    logic [CNT_WIDTH-1:0] tt_q;
    logic [CNT_WIDTH-1:0] stall_q;

    always_comb begin
      sel    = (cnt_sel_chan == CHW'(c));
      xfer   = in_valid[c] & in_ready[c];
      is_sgl = in_data[c*LENGTH + SGL_FLAG_OFFSET];
      stall  = in_valid[c] & chan_mask[c] & ~in_ready[c];
    end

    // A clear on the selected channel overrides a same-cycle increment.
    always_ff @(posedge clk) begin
      if (rst) begin
        sgl_q   <= '0;
        tt_q    <= '0;
        stall_q <= '0;
      end else begin
        if (sel && cnt_load[CNT_SGL])     sgl_q   <= '0;
        else if (xfer && is_sgl)          sgl_q   <= sgl_q + CNT_WIDTH'(1);
        if (sel && cnt_load[CNT_TT])      tt_q    <= '0;
        else if (xfer && !is_sgl)         tt_q    <= tt_q + CNT_WIDTH'(1);
        if (sel && cnt_load[CNT_STALL])   stall_q <= '0;
        else if (stall)                   stall_q <= stall_q + CNT_WIDTH'(1);
      end
    end

    assign cnt_sgl[c]   = sgl_q;
    assign cnt_tt[c]    = tt_q;
    assign cnt_stall[c] = stall_q;
  end

  // Read mux; a clear of the selected counter reads back as 0 immediately.
  always_comb begin
    rd_value = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (cnt_sel_chan == CHW'(i)) begin
        case (cnt_type_e'(cnt_sel_type))
          CNT_SGL:   rd_value = cnt_load[CNT_SGL]   ? '0 : cnt_sgl[i];
          CNT_TT:    rd_value = cnt_load[CNT_TT]    ? '0 : cnt_tt[i];
          CNT_STALL: rd_value = cnt_load[CNT_STALL] ? '0 : cnt_stall[i];
          default:   rd_value = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_value <= '0;
    else     cnt_value <= rd_value;
  end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Self-checking bench for stream_rr_arbiter: table of per-cycle vectors with
// expected in_ready, an output scoreboard, and counter reference model.
module tb_stream_rr_arbiter;

  localparam int unsigned NCH       = 4;
  localparam int unsigned LENGTH    = 128;
  localparam int unsigned CNT_WIDTH = 48;
  localparam int unsigned CHW       = 2;
  localparam int unsigned SGL       = 122;
  localparam int unsigned NVEC      = 20;

  typedef struct {
    logic                 rst;
    logic [NCH-1:0]       valid;
    logic [NCH-1:0]       mask;
    logic                 ordy;
    logic [CHW-1:0]       sel_chan;
    logic [1:0]           sel_type;
    logic [2:0]           load;
    logic [NCH-1:0]       sgl;
    logic [NCH-1:0]       exp_ready;
  } vec_t;

  typedef struct {
    logic [LENGTH-1:0] data;
    logic [CHW-1:0]    chan;
  } beat_t;

  logic                  sys_clk = 1'b0;
  logic                  rst;
  logic [NCH*LENGTH-1:0] in_data;
  logic [NCH-1:0]        in_valid;
  logic [NCH-1:0]        in_ready;
  logic [NCH-1:0]        chan_mask;
  logic [LENGTH-1:0]     out_data;
  logic [CHW-1:0]        out_chan;
  logic                  out_valid;
  logic                  out_ready;
  logic [CHW-1:0]        cnt_sel_chan;
  logic [1:0]            cnt_sel_type;
  logic [2:0]            cnt_load;
  logic [CNT_WIDTH-1:0]  cnt_value;

  always #5 sys_clk = ~sys_clk;

  stream_rr_arbiter #(
    .NCH       (NCH),
    .LENGTH    (LENGTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) dut (
    .clk          (sys_clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .chan_mask    (chan_mask),
    .out_data     (out_data),
    .out_chan     (out_chan),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .cnt_sel_chan (cnt_sel_chan),
    .cnt_sel_type (cnt_sel_type),
    .cnt_load     (cnt_load),
    .cnt_value    (cnt_value)
  );

  beat_t                sb[$];
  logic                 m_ov;
  logic [CNT_WIDTH-1:0] m_cnt [NCH][3];
  logic [CNT_WIDTH-1:0] m_cval;
  logic [LENGTH-1:0]    cur_data [NCH];
  vec_t                 tbl [NVEC];
  int                   vectors = 0;
  int                   miscompares = 0;

  task automatic check(input string name, input logic [LENGTH-1:0] act,
                       input logic [LENGTH-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic [3:0] va, input logic [3:0] ma,
                              input logic o, input logic [1:0] sc, input logic [1:0] st,
                              input logic [2:0] ld, input logic [3:0] sg,
                              input logic [3:0] ex);
    vec_t v;
    v.rst = r; v.valid = va; v.mask = ma; v.ordy = o; v.sel_chan = sc;
    v.sel_type = st; v.load = ld; v.sgl = sg; v.exp_ready = ex;
    return v;
  endfunction

  task automatic model_reset();
    m_ov   = 1'b0;
    m_cval = '0;
    for (int c = 0; c < NCH; c++)
      for (int t = 0; t < 3; t++) m_cnt[c][t] = '0;
    sb.delete();
  endtask

  // One clock: drive at negedge, compare, then advance the reference model.
  task automatic cycle(input vec_t v, input bit keep = 1'b0);
    logic [LENGTH-1:0] d;
    beat_t             b;
    int                g;
    int                t;
    @(negedge sys_clk);
    if (!keep) begin
      for (int c = 0; c < NCH; c++) begin
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        d[SGL] = v.sgl[c];
        cur_data[c] = d;
      end
    end
    rst = v.rst; in_valid = v.valid; chan_mask = v.mask; out_ready = v.ordy;
    cnt_sel_chan = v.sel_chan; cnt_sel_type = v.sel_type; cnt_load = v.load;
    for (int c = 0; c < NCH; c++) in_data[c*LENGTH +: LENGTH] = cur_data[c];
    #1;
    check("in_ready", LENGTH'(in_ready), LENGTH'(v.exp_ready));
    check("out_valid", LENGTH'(out_valid), LENGTH'(m_ov));
    check("cnt_value", LENGTH'(cnt_value), LENGTH'(m_cval));
    if (!v.rst && m_ov && v.ordy) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL scoreboard_empty: got a beat, expected none");
      end else begin
        b = sb.pop_front();
        check("out_data", out_data, b.data);
        check("out_chan", LENGTH'(out_chan), LENGTH'(b.chan));
      end
    end
    if (v.rst) begin
      model_reset();
    end else begin
      t = int'(v.sel_type);
      if (t == 3)       m_cval = '0;
      else if (v.load[t]) m_cval = '0;
      else              m_cval = m_cnt[v.sel_chan][t];
      for (int c = 0; c < NCH; c++) begin
        if (v.sel_chan == CHW'(c) && v.load[0]) m_cnt[c][0] = '0;
        else if (v.exp_ready[c] && cur_data[c][SGL]) m_cnt[c][0] = m_cnt[c][0] + 1;
        if (v.sel_chan == CHW'(c) && v.load[1]) m_cnt[c][1] = '0;
        else if (v.exp_ready[c] && !cur_data[c][SGL]) m_cnt[c][1] = m_cnt[c][1] + 1;
        if (v.sel_chan == CHW'(c) && v.load[2]) m_cnt[c][2] = '0;
        else if (v.valid[c] && v.mask[c] && !v.exp_ready[c]) m_cnt[c][2] = m_cnt[c][2] + 1;
      end
      g = -1;
      for (int c = 0; c < NCH; c++) if (v.exp_ready[c]) g = c;
      if (g >= 0) begin
        b.data = cur_data[g];
        b.chan = CHW'(g);
        sb.push_back(b);
        m_ov = 1'b1;
      end else if (v.ordy) begin
        m_ov = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    cycle(mk(1'b1, 4'b0000, 4'hF, 1'b0, 2'd0, 2'd0, 3'b000, 4'b0000, 4'b0000));
  endtask

  task automatic read_cnt(input int ch, input int t, output logic [CNT_WIDTH-1:0] val);
    cycle(mk(1'b0, 4'b0000, 4'hF, 1'b1, 2'(ch), 2'(t), 3'b000, 4'b0000, 4'b0000));
    @(posedge sys_clk);
    #1;
    val = cnt_value;
  endtask

  task automatic chk_after(input string name, input logic [CNT_WIDTH-1:0] exp);
    @(posedge sys_clk);
    #1;
    check(name, LENGTH'(cnt_value), LENGTH'(exp));
  endtask

  initial begin
    logic [CNT_WIDTH-1:0] s, tt;
    logic [LENGTH-1:0]    held;

    tbl[0]  = mk(0, 4'b0000, 4'b1111, 1, 0, 0, 3'b000, 4'b0000, 4'b0000);
    tbl[1]  = mk(0, 4'b1111, 4'b1111, 1, 0, 0, 3'b000, 4'b1010, 4'b0001);
    tbl[2]  = mk(0, 4'b1111, 4'b1111, 1, 0, 0, 3'b000, 4'b0101, 4'b0010);
    tbl[3]  = mk(0, 4'b1111, 4'b1111, 1, 0, 0, 3'b000, 4'b1111, 4'b0100);
    tbl[4]  = mk(0, 4'b1111, 4'b1111, 1, 0, 0, 3'b000, 4'b0000, 4'b1000);
    tbl[5]  = mk(0, 4'b1111, 4'b1010, 1, 0, 0, 3'b000, 4'b1111, 4'b0010);
    tbl[6]  = mk(0, 4'b1111, 4'b1010, 1, 0, 0, 3'b000, 4'b0000, 4'b1000);
    tbl[7]  = mk(0, 4'b1111, 4'b1010, 1, 0, 0, 3'b000, 4'b1111, 4'b0010);
    tbl[8]  = mk(0, 4'b0001, 4'b1111, 1, 0, 0, 3'b000, 4'b0001, 4'b0001);
    tbl[9]  = mk(0, 4'b0000, 4'b1111, 1, 0, 0, 3'b000, 4'b0000, 4'b0000);
    tbl[10] = mk(0, 4'b0100, 4'b1111, 0, 0, 0, 3'b000, 4'b0100, 4'b0100);
    tbl[11] = mk(0, 4'b0101, 4'b1111, 0, 0, 2, 3'b000, 4'b0000, 4'b0000);
    tbl[12] = mk(0, 4'b0101, 4'b1111, 1, 0, 2, 3'b000, 4'b0000, 4'b0001);
    tbl[13] = mk(0, 4'b0000, 4'b1111, 1, 0, 2, 3'b000, 4'b0000, 4'b0000);
    tbl[14] = mk(0, 4'b0000, 4'b1111, 1, 1, 0, 3'b000, 4'b0000, 4'b0000);
    tbl[15] = mk(0, 4'b0000, 4'b1111, 1, 1, 3, 3'b000, 4'b0000, 4'b0000);
    tbl[16] = mk(0, 4'b0000, 4'b1111, 1, 1, 0, 3'b001, 4'b0000, 4'b0000);
    tbl[17] = mk(0, 4'b0000, 4'b1111, 1, 2, 1, 3'b000, 4'b0000, 4'b0000);
    tbl[18] = mk(0, 4'b1111, 4'b0000, 1, 2, 2, 3'b000, 4'b0000, 4'b0000);
    tbl[19] = mk(0, 4'b0000, 4'b1111, 1, 3, 2, 3'b000, 4'b0000, 4'b0000);

    rst = 1'b1; in_valid = '0; chan_mask = '0; out_ready = 1'b0; in_data = '0;
    cnt_sel_chan = '0; cnt_sel_type = '0; cnt_load = '0;
    for (int c = 0; c < NCH; c++) cur_data[c] = '0;
    repeat (2) @(negedge sys_clk);
    model_reset();

    for (int i = 0; i < NVEC; i++) cycle(tbl[i]);

    // Mask: only channels 1 and 3 alternate, masked channels never stall.
    do_reset();
    for (int k = 0; k < 8; k++)
      cycle(mk(0, 4'b1111, 4'b1010, 1, 0, 0, 3'b000, 4'(k), (k % 2 == 0) ? 4'b0010 : 4'b1000));
    read_cnt(0, 2, s);
    check("mask_stall_ch0", LENGTH'(s), LENGTH'(0));
    read_cnt(2, 2, s);
    check("mask_stall_ch2", LENGTH'(s), LENGTH'(0));

    // Backpressure: word held for 10 cycles, then delivered once.
    do_reset();
    held = 128'hABCD_0000_0000_0000_0000_0000_0000_0001;
    for (int c = 0; c < NCH; c++) cur_data[c] = '0;
    cur_data[2] = held;
    cycle(mk(0, 4'b0100, 4'hF, 1, 0, 0, 3'b000, 4'b0000, 4'b0100), 1'b1);
    for (int k = 0; k < 10; k++) begin
      cycle(mk(0, 4'b0100, 4'hF, 0, 0, 0, 3'b000, 4'b0000, 4'b0000), 1'b1);
      check("hold_data", out_data, held);
    end
    cycle(mk(0, 4'b0000, 4'hF, 1, 0, 0, 3'b000, 4'b0000, 4'b0000), 1'b1);
    read_cnt(2, 2, s);
    check("bp_stall_ch2", LENGTH'(s), LENGTH'(10));

    // Classification of singles vs timetags on channel 1.
    do_reset();
    for (int k = 0; k < 8; k++)
      cycle(mk(0, 4'b0010, 4'hF, 1, 0, 0, 3'b000, (k < 5) ? 4'b0010 : 4'b0000, 4'b0010));
    read_cnt(1, 0, s);
    check("class_sgl", LENGTH'(s), LENGTH'(5));
    read_cnt(1, 1, s);
    check("class_tt", LENGTH'(s), LENGTH'(3));
    read_cnt(1, 3, s);
    check("class_type3", LENGTH'(s), LENGTH'(0));

    // Clear colliding with a singles transfer: clear wins.
    do_reset();
    cycle(mk(0, 4'b0010, 4'hF, 1, 1, 0, 3'b000, 4'b0010, 4'b0010));
    cycle(mk(0, 4'b0000, 4'hF, 1, 1, 0, 3'b000, 4'b0000, 4'b0000));
    chk_after("coll_pre", 48'd1);
    cycle(mk(0, 4'b0010, 4'hF, 1, 1, 0, 3'b001, 4'b0010, 4'b0010));
    chk_after("coll_clear", 48'd0);
    cycle(mk(0, 4'b0000, 4'hF, 1, 1, 0, 3'b000, 4'b0000, 4'b0000));
    chk_after("coll_hold", 48'd0);
    cycle(mk(0, 4'b0010, 4'hF, 1, 1, 0, 3'b000, 4'b0010, 4'b0010));
    cycle(mk(0, 4'b0000, 4'hF, 1, 1, 0, 3'b000, 4'b0000, 4'b0000));
    chk_after("coll_after", 48'd1);

    // Fairness: 400 cycles of all channels eligible.
    do_reset();
    for (int k = 0; k < 400; k++)
      cycle(mk(0, 4'b1111, 4'hF, 1, 0, 0, 3'b000, 4'($urandom_range(0, 15)),
               4'b0001 << (k % 4)));
    for (int c = 0; c < NCH; c++) begin
      read_cnt(c, 0, s);
      read_cnt(c, 1, tt);
      check("fair_total", LENGTH'(s + tt), LENGTH'(100));
    end

    // Reset while a word is held and counters are non-zero.
    cycle(mk(0, 4'b0100, 4'hF, 1, 0, 0, 3'b000, 4'b0000, 4'b0100));
    cycle(mk(1, 4'b1111, 4'hF, 0, 0, 0, 3'b000, 4'b0000, 4'b0000));
    @(posedge sys_clk);
    #1;
    check("rst_out_valid", LENGTH'(out_valid), LENGTH'(0));
    for (int c = 0; c < NCH; c++)
      for (int t = 0; t < 3; t++) begin
        read_cnt(c, t, s);
        check("rst_counter", LENGTH'(s), LENGTH'(0));
      end
    cycle(mk(0, 4'b1010, 4'hF, 1, 0, 0, 3'b000, 4'b0000, 4'b0010));
    cycle(mk(0, 4'b0000, 4'hF, 1, 0, 0, 3'b000, 4'b0000, 4'b0000));
    cycle(mk(0, 4'b0000, 4'hF, 1, 0, 0, 3'b000, 4'b0000, 4'b0000));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
